// File: rtl/log_capture_if.sv
// Packet bus from the capture sequencer to the DRAM packer.
interface log_capture_if;
  logic        write_enable;
  logic [31:0] sample_number;
  logic [31:0] samplePacket;
  logic        pageFull;

  modport master (output write_enable, output sample_number, output samplePacket, output pageFull);
  modport slave  (input  write_enable, input  sample_number, input  samplePacket, input  pageFull);
endinterface

// File: rtl/log_capture.sv
// Logic-analyzer trigger/capture sequencer: pre-trigger ring, edge/pattern trigger,
// fixed post-trigger window, one registered 32-bit packet per captured sample.
module log_capture (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   sampleData,
  input  logic [31:0]   maxSampleCount,
  input  logic [31:0]   preTriggerSampleCountMax,
  input  logic [15:0]   desiredPattern,
  input  logic [15:0]   activeChannels,
  input  logic [15:0]   dontCareChannels,
  input  logic [7:0]    edgeChannel,
  input  logic          patternTriggerEnable,
  input  logic          edgeTriggerEnable,
  input  logic          edgeType,
  input  logic          start,
  input  logic          abort,
  output logic          idle,
  output logic          preTrigger,
  output logic          postTrigger,
  log_capture_if.master bus
);

  localparam int unsigned CHW = 16;
  localparam int unsigned TSW = 15;
  localparam int unsigned NW  = 32;

  typedef logic [NW-1:0] num_t;
  typedef logic [NW:0]   wide_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nx;

  logic           start_q;
  logic [CHW-1:0] prev;
  logic [TSW-1:0] ts;
  num_t           ptr;
  num_t           post_cnt;

  logic [CHW-1:0] m;
  logic           start_edge;
  logic [3:0]     edge_idx;
  logic           edge_hit;
  logic           pattern_hit;
  logic           trig;
  num_t           p;
  num_t           last_num;
  logic           ptr_wrap;
  num_t           ptr_next;
  logic           capturing;

  logic           we_d;
  num_t           num_d;
  logic           mark_d;
  logic           pf_d;

  assign m           = sampleData & activeChannels;
  assign start_edge  = start & ~start_q;
  assign p           = preTriggerSampleCountMax;
  assign edge_idx    = edgeChannel[3:0];
  assign pattern_hit = ((m ^ desiredPattern) & ~dontCareChannels) == '0;
  assign capturing   = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);

  // Last slot is max(maxSampleCount, P+1)-1; the trigger slot P is always written.
  assign last_num = (wide_t'(maxSampleCount) > (wide_t'(p) + wide_t'(1))) ?
                    (maxSampleCount - num_t'(1)) : p;
  assign ptr_wrap = (wide_t'(ptr) + wide_t'(1)) >= wide_t'(p);
  assign ptr_next = ptr_wrap ? '0 : (ptr + num_t'(1));

  always_comb begin
    edge_hit = 1'b0;
    if (edgeChannel < 8'd16) begin
      edge_hit = edgeType ? (~prev[edge_idx] & m[edge_idx])
                          : (prev[edge_idx] & ~m[edge_idx]);
    end
  end

  // With no trigger source enabled the first armed sample triggers.
  assign trig = (~edgeTriggerEnable & ~patternTriggerEnable) |
                (edgeTriggerEnable & edge_hit) |
                (patternTriggerEnable & pattern_hit);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_edge) state_nx = (p == '0) ? S_ARMED : S_FILL;
      end
      S_FILL: begin
        if (abort)         state_nx = S_DONE;
        else if (ptr_wrap) state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (abort)     state_nx = S_DONE;
        else if (trig) state_nx = (last_num == p) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (abort || (post_cnt == last_num)) state_nx = S_DONE;
      end
      S_DONE: begin
        if (!start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    num_d  = '0;
    mark_d = 1'b0;
    pf_d   = capturing && (state_nx == S_DONE);
    if (capturing && !abort) begin
      we_d = 1'b1;
      case (state)
        S_FILL:  num_d = ptr;
        S_ARMED: begin
          mark_d = trig;
          num_d  = trig ? p : ptr;
        end
        S_POST:  num_d = post_cnt;
        default: num_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q           <= 1'b0;
      prev              <= '0;
      ts                <= '0;
      ptr               <= '0;
      post_cnt          <= '0;
      idle              <= 1'b1;
      preTrigger        <= 1'b0;
      postTrigger       <= 1'b0;
      bus.write_enable  <= 1'b0;
      bus.sample_number <= '0;
      bus.samplePacket  <= '0;
      bus.pageFull      <= 1'b0;
    end else begin
      start_q <= start;
      prev    <= m;
      ts      <= ((state == S_IDLE) && start_edge) ? '0 : (ts + TSW'(1));

      case (state)
        S_IDLE:          if (start_edge) ptr <= '0;
        S_FILL, S_ARMED: ptr <= ptr_next;
        default:         ptr <= ptr;
      endcase

      if (state == S_ARMED)     post_cnt <= p + num_t'(1);
      else if (state == S_POST) post_cnt <= post_cnt + num_t'(1);

      idle              <= (state_nx == S_IDLE) || (state_nx == S_DONE);
      preTrigger        <= (state_nx == S_FILL) || (state_nx == S_ARMED);
      postTrigger       <= (state_nx == S_POST);
      bus.write_enable  <= we_d;
      bus.sample_number <= num_d;
      bus.samplePacket  <= we_d ? {mark_d, ts, m} : '0;
      bus.pageFull      <= pf_d;
    end
  end

endmodule

// File: tb/tb_log_capture.sv
// Scoreboard bench for log_capture: trigger table plus hand-written capture sequences.
module tb_log_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sampleData;
  logic [31:0] maxSampleCount;
  logic [31:0] preTriggerSampleCountMax;
  logic [15:0] desiredPattern;
  logic [15:0] activeChannels;
  logic [15:0] dontCareChannels;
  logic [7:0]  edgeChannel;
  logic        patternTriggerEnable;
  logic        edgeTriggerEnable;
  logic        edgeType;
  logic        start;
  logic        abort;
  logic        idle;
  logic        preTrigger;
  logic        postTrigger;

  log_capture_if bus();

  log_capture dut (
    .clk                      (clk),
    .reset                    (reset),
    .sampleData               (sampleData),
    .maxSampleCount           (maxSampleCount),
    .preTriggerSampleCountMax (preTriggerSampleCountMax),
    .desiredPattern           (desiredPattern),
    .activeChannels           (activeChannels),
    .dontCareChannels         (dontCareChannels),
    .edgeChannel              (edgeChannel),
    .patternTriggerEnable     (patternTriggerEnable),
    .edgeTriggerEnable        (edgeTriggerEnable),
    .edgeType                 (edgeType),
    .start                    (start),
    .abort                    (abort),
    .idle                     (idle),
    .preTrigger               (preTrigger),
    .postTrigger              (postTrigger),
    .bus                      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] num;
    logic [31:0] pkt;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] act;
    logic [15:0] des;
    logic [15:0] dc;
    logic [15:0] prv;
    logic [15:0] dat;
    logic [7:0]  ech;
    logic        etype;
    logic        pe;
    logic        ee;
    logic        exp_trig;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   pf_count = 0;
  int   wr_count = 0;
  int   trig_count = 0;
  int   mode = 0;

  // Output monitor: every write must match the oldest expected packet.
  always @(negedge clk) begin
    if (bus.pageFull === 1'b1) pf_count++;
    if (bus.write_enable === 1'b1) begin
      wr_count++;
      if (bus.samplePacket[31]) trig_count++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got num=%0d pkt=%h required=no write",
                 bus.sample_number, bus.samplePacket);
      end else begin
        mon_e = sb.pop_front();
        if (bus.sample_number !== mon_e.num || bus.samplePacket !== mon_e.pkt) begin
          bad++;
          $display("FAIL packet got num=%0d pkt=%h required num=%0d pkt=%h",
                   bus.sample_number, bus.samplePacket, mon_e.num, mon_e.pkt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] gen(input int k);
    case (mode)
      1:       gen = (16'(k * 37) & 16'hFFF7) | ((k >= 75) ? 16'h0008 : 16'h0000);
      2:       gen = (k < 5 || k == 9) ? 16'hA512 : {8'hA4, 8'(k)};
      3:       gen = 16'($urandom);
      default: gen = 16'h1234;
    endcase
  endfunction

  function automatic logic trig_model(input logic [15:0] mm, input logic [15:0] pm);
    logic eh;
    logic ph;
    eh = 1'b0;
    if (edgeChannel < 8'd16)
      eh = edgeType ? (!pm[edgeChannel[3:0]] && mm[edgeChannel[3:0]])
                    : (pm[edgeChannel[3:0]] && !mm[edgeChannel[3:0]]);
    ph = ((mm ^ desiredPattern) & ~dontCareChannels) == 16'h0000;
    if (!edgeTriggerEnable && !patternTriggerEnable) return 1'b1;
    return (edgeTriggerEnable && eh) || (patternTriggerEnable && ph);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sampleData = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int p, input int mx, input logic pe, input logic ee,
                         input logic et, input logic [7:0] ech, input logic [15:0] des,
                         input logic [15:0] dc, input logic [15:0] act);
    preTriggerSampleCountMax = 32'(p);
    maxSampleCount           = 32'(mx);
    patternTriggerEnable     = pe;
    edgeTriggerEnable        = ee;
    edgeType                 = et;
    edgeChannel              = ech;
    desiredPattern           = des;
    dontCareChannels         = dc;
    activeChannels           = act;
  endtask

  // Drives one capture, pushing the expected packet for every written sample.
  task automatic run_capture(input string name, input int p, input int mx, input int abort_k,
                             input int n_max, input int exp_wr, input int exp_tr);
    logic [15:0] d;
    logic [15:0] mm;
    logic [15:0] pm;
    int   ph;
    int   ptr;
    int   pn;
    int   last;
    exp_t e;
    pf_count = 0;
    wr_count = 0;
    trig_count = 0;
    @(negedge clk);
    d = gen(-1);
    sampleData = d;
    start = 1'b1;
    pm = d & activeChannels;
    ph = (p == 0) ? 1 : 0;
    ptr = 0;
    pn = 0;
    last = (mx > p + 1) ? mx - 1 : p;
    for (int k = 0; k < n_max && ph != 3; k++) begin
      @(negedge clk);
      d = gen(k);
      sampleData = d;
      mm = d & activeChannels;
      if (k == abort_k) begin
        abort = 1'b1;
        ph = 3;
      end else begin
        e.pkt = {1'b0, 15'(k), mm};
        e.num = 32'(ptr);
        case (ph)
          0: begin
            ptr++;
            if (ptr == p) begin
              ph = 1;
              ptr = 0;
            end
          end
          1: begin
            if (trig_model(mm, pm)) begin
              e.num = 32'(p);
              e.pkt[31] = 1'b1;
              if (last == p) ph = 3;
              else begin
                ph = 2;
                pn = p + 1;
              end
            end else begin
              ptr = (ptr + 1 >= p) ? 0 : ptr + 1;
            end
          end
          default: begin
            e.num = 32'(pn);
            if (pn == last) ph = 3;
            pn++;
          end
        endcase
        sb.push_back(e);
      end
      pm = mm;
    end
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
    check({name, "_writes"}, 32'(wr_count), 32'(exp_wr));
    check({name, "_trigs"}, 32'(trig_count), 32'(exp_tr));
    check({name, "_pagefull"}, 32'(pf_count), 32'd1);
    check({name, "_idle"}, {29'd0, idle, preTrigger, postTrigger}, 32'h4);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  vec_t vt[12];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sampleData = 16'h0000;
    set_cfg(0, 1, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0000, 16'h0000, 16'hFFFF);

    vt[0]  = '{"pat_hit",   16'hFFFF, 16'hA5A5, 16'h00FF, 16'h0000, 16'hA512, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{"pat_miss",  16'hFFFF, 16'hA5A5, 16'h00FF, 16'h0000, 16'hA412, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{"rise_hit",  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 8'd3,  1'b1, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{"rise_hold", 16'hFFFF, 16'h0000, 16'h0000, 16'h0008, 16'h0008, 8'd3,  1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{"fall_hit",  16'hFFFF, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 8'd3,  1'b0, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{"fall_dir",  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{"ch20",      16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{"none_en",   16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{"mask_pat",  16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{"mask_edge", 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 8'd15, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{"both_or",   16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    vt[11] = '{"dc_all",    16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h5555, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_we", {31'd0, bus.write_enable}, 32'd0);
    check("rst_pf", {31'd0, bus.pageFull}, 32'd0);
    check("rst_num", bus.sample_number, 32'd0);
    check("rst_phase", {30'd0, preTrigger, postTrigger}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single-sample trigger vectors: P=0, max=1, abort right after the sample.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      set_cfg(0, 1, vt[i].pe, vt[i].ee, vt[i].etype, vt[i].ech, vt[i].des, vt[i].dc, vt[i].act);
      pf_count = 0;
      @(negedge clk);
      sampleData = vt[i].prv;
      start = 1'b1;
      @(negedge clk);
      sampleData = vt[i].dat;
      sb.push_back('{32'd0, {vt[i].exp_trig, 15'd0, vt[i].dat & vt[i].act}});
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (2) @(negedge clk);
      check({vt[i].name, "_drain"}, 32'(sb.size()), 32'd0);
      check({vt[i].name, "_pf"}, 32'(pf_count), 32'd1);
      check({vt[i].name, "_idle"}, {31'd0, idle}, 32'd1);
      start = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Edge trigger on ch3 rising at sample 75: 30 fill + 45 armed + 1 trigger + 69 post.
    do_reset();
    mode = 1;
    set_cfg(30, 100, 1'b0, 1'b1, 1'b1, 8'd3, 16'h0000, 16'h0000, 16'hFFFF);
    run_capture("edge", 30, 100, -1, 300, 145, 1);

    // Pattern trigger; matching samples during fill are ignored.
    do_reset();
    mode = 2;
    set_cfg(5, 12, 1'b1, 1'b0, 1'b1, 8'd0, 16'hA5A5, 16'h00FF, 16'hFFFF);
    run_capture("pattern", 5, 12, -1, 100, 16, 1);

    // Out-of-range edge channel never fires; ring wraps until abort.
    do_reset();
    mode = 3;
    set_cfg(4, 10, 1'b0, 1'b1, 1'b0, 8'd20, 16'h0000, 16'h0000, 16'hFFFF);
    run_capture("ch20_wrap", 4, 10, 40, 100, 40, 0);

    // Abort in ARMED; start stays high afterwards without restarting.
    do_reset();
    mode = 3;
    set_cfg(3, 20, 1'b0, 1'b1, 1'b1, 8'd20, 16'h0000, 16'h0000, 16'hFFFF);
    run_capture("abort", 3, 20, 6, 100, 6, 0);

    // Fresh start edge after the abort, no reset: P=0, max=1, triggers off.
    mode = 0;
    set_cfg(0, 1, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0000, 16'h0000, 16'hFFFF);
    run_capture("p0_max1", 0, 1, -1, 20, 1, 1);

    // max below P+1: trigger sample is the final write.
    set_cfg(2, 2, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0000, 16'h0000, 16'hFFFF);
    run_capture("max_small", 2, 2, -1, 20, 3, 1);

    // Reset during fill: back to idle with no pageFull.
    mode = 3;
    set_cfg(10, 20, 1'b0, 1'b0, 1'b1, 8'd0, 16'h0000, 16'h0000, 16'hFFFF);
    pf_count = 0;
    @(negedge clk);
    sampleData = 16'h0000;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sampleData = gen(k);
      sb.push_back('{32'(k), {1'b0, 15'(k), sampleData}});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_idle", {31'd0, idle}, 32'd1);
    check("rst_mid_we", {31'd0, bus.write_enable}, 32'd0);
    check("rst_mid_pf", 32'(pf_count), 32'd0);
    check("rst_mid_drain", 32'(sb.size()), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
